// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register for the five-stage MIPS core: decodes the ALU operation,
// selects immediates and forwards EX/MEM and MEM/WB results onto the ALU operand buses.
module alu_issue_stage #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               id_valid,
   input  logic [5:0]         id_opcode,
   input  logic [5:0]         id_funct,
   input  logic [REGBITS-1:0] id_rs,
   input  logic [REGBITS-1:0] id_rt,
   input  logic [REGBITS-1:0] id_rd,
   input  logic [WIDTH-1:0]   id_rs_data,
   input  logic [WIDTH-1:0]   id_rt_data,
   input  logic [15:0]        id_imm16,
   input  logic               stall,
   input  logic               flush,
   input  logic               exmem_regwrite,
   input  logic [REGBITS-1:0] exmem_rd,
   input  logic [WIDTH-1:0]   exmem_result,
   input  logic               memwb_regwrite,
   input  logic [REGBITS-1:0] memwb_rd,
   input  logic [WIDTH-1:0]   memwb_result,
   output logic [WIDTH-1:0]   BussA,
   output logic [WIDTH-1:0]   BussB,
   output logic [1:0]         ALUControl,
   output logic               ex_valid,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_branch,
   output logic [REGBITS-1:0] ex_dest,
   output logic [WIDTH-1:0]   ex_store_data,
   output logic               illegal,
   output logic               load_use
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_XOR  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_SLT  = 2'b11;

   typedef struct packed {
      logic               valid;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic               illegal;
      logic               use_imm;
      logic [1:0]         alu_ctl;
      logic [REGBITS-1:0] dest;
      logic [REGBITS-1:0] rs;
      logic [REGBITS-1:0] rt;
      logic [WIDTH-1:0]   rs_data;
      logic [WIDTH-1:0]   rt_data;
      logic [WIDTH-1:0]   imm;
   } idex_t;

   idex_t              r_idex;
   idex_t              w_idex_next;
   idex_t              w_decoded;
   logic               w_legal;
   logic               w_writes;
   logic               w_memread;
   logic               w_memwrite;
   logic               w_branch;
   logic               w_use_imm;
   logic [1:0]         w_alu;
   logic [REGBITS-1:0] w_dest;
   logic [WIDTH-1:0]   w_imm;
   logic [WIDTH-1:0]   w_sext;
   logic [WIDTH-1:0]   w_zext;
   logic [WIDTH-1:0]   w_fwd_a;
   logic [WIDTH-1:0]   w_fwd_b;
   logic               w_id_reads_rt;

   assign w_sext = {{(WIDTH-16){id_imm16[15]}}, id_imm16};
   assign w_zext = {{(WIDTH-16){1'b0}}, id_imm16};

   always_comb begin
      w_legal    = 1'b0;
      w_writes   = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_branch   = 1'b0;
      w_use_imm  = 1'b0;
      w_alu      = ALU_ADD;
      w_dest     = '0;
      w_imm      = w_sext;
      case (id_opcode)
         OP_RTYPE: begin
            w_dest   = id_rd;
            w_writes = 1'b1;
            case (id_funct)
               FN_ADD:  begin w_legal = 1'b1; w_alu = ALU_ADD; end
               FN_SUB:  begin w_legal = 1'b1; w_alu = ALU_SUB; end
               FN_XOR:  begin w_legal = 1'b1; w_alu = ALU_XOR; end
               FN_SLT:  begin w_legal = 1'b1; w_alu = ALU_SLT; end
               default: w_legal = 1'b0;
            endcase
         end
         OP_ADDI: begin w_legal = 1'b1; w_use_imm = 1'b1; w_dest = id_rt; w_writes = 1'b1; end
         OP_SLTI: begin
            w_legal = 1'b1; w_use_imm = 1'b1; w_dest = id_rt; w_writes = 1'b1; w_alu = ALU_SLT;
         end
         OP_XORI: begin
            w_legal = 1'b1; w_use_imm = 1'b1; w_dest = id_rt; w_writes = 1'b1; w_alu = ALU_XOR;
            w_imm = w_zext;
         end
         OP_LW: begin
            w_legal = 1'b1; w_use_imm = 1'b1; w_dest = id_rt; w_writes = 1'b1; w_memread = 1'b1;
         end
         OP_SW:   begin w_legal = 1'b1; w_use_imm = 1'b1; w_memwrite = 1'b1; end
         OP_BEQ:  begin w_legal = 1'b1; w_branch = 1'b1; w_alu = ALU_SUB; end
         default: w_legal = 1'b0;
      endcase

      // Anything not captured as a real instruction enters EX as an all-zero bubble.
      w_decoded = '0;
      if (id_valid && w_legal) begin
         w_decoded.valid    = 1'b1;
         w_decoded.regwrite = w_writes && (w_dest != '0);
         w_decoded.memread  = w_memread;
         w_decoded.memwrite = w_memwrite;
         w_decoded.branch   = w_branch;
         w_decoded.use_imm  = w_use_imm;
         w_decoded.alu_ctl  = w_alu;
         w_decoded.dest     = w_dest;
         w_decoded.rs       = id_rs;
         w_decoded.rt       = id_rt;
         w_decoded.rs_data  = id_rs_data;
         w_decoded.rt_data  = id_rt_data;
         w_decoded.imm      = w_imm;
      end
      w_decoded.illegal = id_valid && !w_legal;
   end

   always_comb begin
      w_idex_next         = r_idex;
      w_idex_next.illegal = 1'b0;
      if (flush) begin
         w_idex_next = '0;
      end else if (!stall) begin
         w_idex_next = w_decoded;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idex <= '0;
      end else begin
         r_idex <= w_idex_next;
      end
   end

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   assign w_fwd_a = (exmem_regwrite && (exmem_rd == r_idex.rs) && (r_idex.rs != '0)) ? exmem_result :
                    (memwb_regwrite && (memwb_rd == r_idex.rs) && (r_idex.rs != '0)) ? memwb_result :
                    r_idex.rs_data;
   assign w_fwd_b = (exmem_regwrite && (exmem_rd == r_idex.rt) && (r_idex.rt != '0)) ? exmem_result :
                    (memwb_regwrite && (memwb_rd == r_idex.rt) && (r_idex.rt != '0)) ? memwb_result :
                    r_idex.rt_data;

   assign BussA         = w_fwd_a;
   assign BussB         = r_idex.use_imm ? r_idex.imm : w_fwd_b;
   assign ALUControl    = r_idex.alu_ctl;
   assign ex_valid      = r_idex.valid;
   assign ex_regwrite   = r_idex.regwrite;
   assign ex_memread    = r_idex.memread;
   assign ex_memwrite   = r_idex.memwrite;
   assign ex_branch     = r_idex.branch;
   assign ex_dest       = r_idex.dest;
   assign ex_store_data = w_fwd_b;
   assign illegal       = r_idex.illegal;

   assign w_id_reads_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
   assign load_use = r_idex.valid && r_idex.memread && (r_idex.dest != '0) &&
                     ((r_idex.dest == id_rs) || ((r_idex.dest == id_rt) && w_id_reads_rt));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand-built hazard/reset sequences,
// then random traffic checked against an instruction-level model of the EX stage.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [5:0]  id_opcode = '0;
   logic [5:0]  id_funct = '0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0;
   logic [15:0] id_imm16 = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        exmem_regwrite = 1'b0;
   logic [4:0]  exmem_rd = '0;
   logic [31:0] exmem_result = '0;
   logic        memwb_regwrite = 1'b0;
   logic [4:0]  memwb_rd = '0;
   logic [31:0] memwb_result = '0;
   logic [31:0] BussA, BussB, ex_store_data;
   logic [1:0]  ALUControl;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, illegal, load_use;
   logic [4:0]  ex_dest;

   alu_issue_stage #(.WIDTH(32), .REGBITS(5)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
      .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .BussA(BussA), .BussB(BussB), .ALUControl(ALUControl), .ex_valid(ex_valid),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_branch(ex_branch), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
      .illegal(illegal), .load_use(load_use)
   );

   always #5 clk = ~clk;

   // {BussA, BussB, ALUControl, valid, regwrite, memread, memwrite, branch, dest, store_data, illegal, load_use}
   logic [109:0] w_act;
   assign w_act = {BussA, BussB, ALUControl, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                   ex_branch, ex_dest, ex_store_data, illegal, load_use};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [109:0] act, input logic [109:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: %h", name, act);
      end
   endtask

   task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
      id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
   endtask

   typedef struct {
      logic        v;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd;
      logic [15:0] imm;
      logic        exw;
      logic [4:0]  exrd;
      logic [31:0] exres;
      logic        mww;
      logic [4:0]  mwrd;
      logic [31:0] mwres;
      logic [31:0] ea, eb;
      logic [1:0]  ectl;
      logic        ev, erw, emr, emw, ebr;
      logic [4:0]  edst;
      logic [31:0] esd;
      logic        eill;
   } vec_t;

   // Captured instruction as seen by the EX stage (bubble when present == 0).
   typedef struct {
      bit          present;
      bit          ill;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd;
      logic [15:0] imm;
   } inst_t;

   inst_t m_ex;

   function automatic bit supported(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h26, 6'h2A};
      return op inside {6'h04, 6'h08, 6'h0A, 6'h0E, 6'h23, 6'h2B};
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
      if (exmem_regwrite && r != 5'd0 && exmem_rd == r) return exmem_result;
      if (memwb_regwrite && r != 5'd0 && memwb_rd == r) return memwb_result;
      return rf;
   endfunction

   function automatic logic [109:0] model_out();
      logic [31:0] a, b, sd, sx, zx;
      logic [1:0]  ctl;
      logic        mr, mw, br, writes, rw, lu;
      logic [4:0]  dest;
      if (!m_ex.present) return {108'b0, m_ex.ill, 1'b0};
      sx = {{16{m_ex.imm[15]}}, m_ex.imm};
      zx = {16'h0000, m_ex.imm};
      a = fwd(m_ex.rs, m_ex.rsd);
      sd = fwd(m_ex.rt, m_ex.rtd);
      b = sd; ctl = 2'b00; mr = 1'b0; mw = 1'b0; br = 1'b0; writes = 1'b0; dest = 5'd0;
      case (m_ex.op)
         6'h00: begin
            dest = m_ex.rd; writes = 1'b1;
            case (m_ex.fn)
               6'h22:   ctl = 2'b10;
               6'h26:   ctl = 2'b01;
               6'h2A:   ctl = 2'b11;
               default: ctl = 2'b00;
            endcase
         end
         6'h08: begin b = sx; dest = m_ex.rt; writes = 1'b1; end
         6'h0A: begin b = sx; ctl = 2'b11; dest = m_ex.rt; writes = 1'b1; end
         6'h0E: begin b = zx; ctl = 2'b01; dest = m_ex.rt; writes = 1'b1; end
         6'h23: begin b = sx; mr = 1'b1; dest = m_ex.rt; writes = 1'b1; end
         6'h2B: begin b = sx; mw = 1'b1; end
         6'h04: begin ctl = 2'b10; br = 1'b1; end
         default: ;
      endcase
      rw = writes && dest != 5'd0;
      lu = mr && dest != 5'd0 &&
           (dest == id_rs || (dest == id_rt && (id_opcode inside {6'h00, 6'h2B, 6'h04})));
      return {a, b, ctl, 1'b1, rw, mr, mw, br, dest, sd, 1'b0, lu};
   endfunction

   vec_t vecs[14];
   logic [5:0] op_pool[9];
   logic [5:0] fn_pool[6];

   initial begin
      vecs[0]  = '{1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h00000DEF, 32'h00000ABC, 16'h0000,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000DEF, 32'h00000ABC, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h00000ABC, 1'b0};
      vecs[1]  = '{1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'h00000005, 32'h00000007, 16'hFFFF,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000005, 32'hFFFFFFFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h00000007, 1'b0};
      vecs[2]  = '{1'b1, 6'h0E, 6'h00, 5'd1, 5'd4, 5'd0, 32'h00000005, 32'h00000009, 16'hFFFF,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000005, 32'h0000FFFF, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h00000009, 1'b0};
      vecs[3]  = '{1'b1, 6'h00, 6'h22, 5'd1, 5'd5, 5'd4, 32'h00000011, 32'h00000022, 16'h0000,
                   1'b1, 5'd1, 32'h80000000, 1'b1, 5'd1, 32'h12345678,
                   32'h80000000, 32'h00000022, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h00000022, 1'b0};
      vecs[4]  = '{1'b1, 6'h00, 6'h22, 5'd0, 5'd5, 5'd4, 32'h0000AAAA, 32'h00000022, 16'h0000,
                   1'b1, 5'd0, 32'h80000000, 1'b1, 5'd0, 32'h12345678,
                   32'h0000AAAA, 32'h00000022, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h00000022, 1'b0};
      vecs[5]  = '{1'b1, 6'h0A, 6'h00, 5'd1, 5'd6, 5'd0, 32'h00000003, 32'h00000000, 16'h8000,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000003, 32'hFFFF8000, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h00000000, 1'b0};
      vecs[6]  = '{1'b1, 6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 32'h00000100, 32'h00000055, 16'h0004,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000100, 32'h00000004, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h00000055, 1'b0};
      vecs[7]  = '{1'b1, 6'h2B, 6'h00, 5'd2, 5'd5, 5'd0, 32'h00000200, 32'h00000077, 16'hFFF8,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h00000BAD,
                   32'h00000200, 32'hFFFFFFF8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00000BAD, 1'b0};
      vecs[8]  = '{1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'h00000010, 32'h00000010, 16'h0003,
                   1'b1, 5'd2, 32'h00000099, 1'b0, 5'd0, 32'h0,
                   32'h00000010, 32'h00000099, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00000099, 1'b0};
      vecs[9]  = '{1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h00000010, 32'h00000020, 16'h0000,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
      vecs[10] = '{1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h00000010, 32'h00000020, 16'h0000,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
      vecs[11] = '{1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'h00000031, 32'h00000042, 16'h0000,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h00000031, 32'h00000042, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h00000042, 1'b0};
      vecs[12] = '{1'b1, 6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'h00000010, 32'h00000020, 16'h1234,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
      vecs[13] = '{1'b1, 6'h00, 6'h26, 5'd9, 5'd10, 5'd8, 32'h00000001, 32'h00000002, 16'h0000,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h0000CAFE,
                   32'h00000001, 32'h0000CAFE, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0000CAFE, 1'b0};

      op_pool = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h3F};
      fn_pool = '{6'h20, 6'h22, 6'h26, 6'h2A, 6'h3F, 6'h00};

      // Reset holds EX empty even with a valid instruction presented.
      set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
      repeat (3) @(negedge clk);
      check("reset_state", w_act, 110'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         set_id(vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                vecs[i].rsd, vecs[i].rtd, vecs[i].imm);
         exmem_regwrite = vecs[i].exw; exmem_rd = vecs[i].exrd; exmem_result = vecs[i].exres;
         memwb_regwrite = vecs[i].mww; memwb_rd = vecs[i].mwrd; memwb_result = vecs[i].mwres;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), w_act,
               {vecs[i].ea, vecs[i].eb, vecs[i].ectl, vecs[i].ev, vecs[i].erw, vecs[i].emr,
                vecs[i].emw, vecs[i].ebr, vecs[i].edst, vecs[i].esd, vecs[i].eill, 1'b0});
      end
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

      // Load-use: lw r7 in EX, slt r2,r7,r3 in ID; stall, then flush, then recapture.
      set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 32'h40, 32'h0, 16'h0000);
      @(posedge clk); @(negedge clk);
      set_id(1'b1, 6'h00, 6'h2A, 5'd7, 5'd3, 5'd2, 32'h111, 32'h5, 16'h0000);
      #1 check("lu_detect", 110'(load_use), 110'(1'b1));
      stall = 1'b1;
      @(posedge clk); @(negedge clk);
      check("lu_stall_hold", 110'({ex_valid, ex_memread, ex_dest, load_use}), 110'({1'b1, 1'b1, 5'd7, 1'b1}));
      stall = 1'b0; flush = 1'b1;
      @(posedge clk); @(negedge clk);
      check("lu_flush", 110'({ex_valid, ex_regwrite, load_use}), 110'(3'b000));
      flush = 1'b0;
      memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h0000DA7A;
      @(posedge clk); @(negedge clk);
      check("lu_fwd_slt", 110'({ALUControl, BussA, BussB, ex_dest}), 110'({2'b11, 32'h0000DA7A, 32'h5, 5'd2}));
      memwb_regwrite = 1'b0;

      // Illegal pulses once; held by stall it must not repeat.
      set_id(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
      @(posedge clk); @(negedge clk);
      check("ill_pulse", 110'({illegal, ex_regwrite, ex_valid}), 110'(3'b100));
      set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
      @(posedge clk); @(negedge clk);
      check("ill_once", 110'({illegal, ex_valid}), 110'(2'b01));
      set_id(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
      @(posedge clk); @(negedge clk);
      check("ill_pulse2", 110'(illegal), 110'(1'b1));
      stall = 1'b1;
      @(posedge clk); @(negedge clk);
      check("ill_stall1", 110'(illegal), 110'(1'b0));
      @(posedge clk); @(negedge clk);
      check("ill_stall2", 110'(illegal), 110'(1'b0));
      stall = 1'b0;

      // Async reset while stalled, then beq captured on the first edge after release.
      set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h00000DEF, 32'h00000ABC, 16'h0);
      @(posedge clk); @(negedge clk);
      check("pre_reset_add", 110'({ex_valid, BussA}), 110'({1'b1, 32'h00000DEF}));
      stall = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset", w_act, 110'b0);
      @(negedge clk);
      reset_n = 1'b1; stall = 1'b0;
      set_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 16'h0);
      @(posedge clk); @(negedge clk);
      check("beq_after_reset", 110'({ALUControl, ex_branch, ex_regwrite, ex_valid}), 110'({2'b10, 1'b1, 1'b0, 1'b1}));

      // Random traffic against the instruction-level model, starting from a flushed EX.
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      m_ex = '{default: '0};
      for (int c = 0; c < 300; c++) begin
         set_id($urandom_range(0, 9) != 0, op_pool[$urandom_range(0, 8)], fn_pool[$urandom_range(0, 5)],
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom, $urandom, 16'($urandom));
         exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
         memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
         stall = ($urandom_range(0, 6) == 0);
         flush = ($urandom_range(0, 9) == 0);
         #1 check($sformatf("rand%0d", c), w_act, model_out());
         @(posedge clk);
         if (flush) begin
            m_ex = '{default: '0};
         end else if (stall) begin
            m_ex.ill = 1'b0;
         end else begin
            m_ex.present = id_valid && supported(id_opcode, id_funct);
            m_ex.ill     = id_valid && !supported(id_opcode, id_funct);
            m_ex.op = id_opcode; m_ex.fn = id_funct;
            m_ex.rs = id_rs; m_ex.rt = id_rt; m_ex.rd = id_rd;
            m_ex.rsd = id_rs_data; m_ex.rtd = id_rt_data; m_ex.imm = id_imm16;
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
